gain_update_sched: RTL and testbench

//  Scheduler for the PLL loop-filter gain registers (Kp, Ki, Kd).

---
 rtl/gain_update_sched.sv | 159 +++++++++++++++
 tb/tb_gain_update_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_update_sched.sv
// Round-robin scheduler for the PLL loop-filter gains (kp, ki, kd).
// Applies one signed increment at a time with clamping to [G_MIN, G_MAX].
// After each update it holds a settle interval before granting again.
//
// state  | meaning
// IDLE   | waiting for an unfrozen request; grants round-robin from rr_ptr
// APPLY  | one cycle; the latched increment is added and clamped
// SETTLE | down-counter runs to zero; requests wait
module gain_update_sched #(
  parameter int GAIN_W     = 8,
  parameter int SETTLE_CYC = 16,
  parameter int KP_INIT    = 12,
  parameter int KI_INIT    = 4,
  parameter int KD_INIT    = 0,
  parameter int G_MIN      = 3,
  parameter int G_MAX      = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [GAIN_W-1:0] inc_kp,
  input  logic [GAIN_W-1:0] inc_ki,
  input  logic [GAIN_W-1:0] inc_kd,
  input  logic              freeze,
  output logic [GAIN_W-1:0] kp,
  output logic [GAIN_W-1:0] ki,
  output logic [GAIN_W-1:0] kd,
  output logic [2:0]        ack,
  output logic [2:0]        sat_flag,
  output logic              busy
);

  localparam int SUM_W = GAIN_W + 2;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(G_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(G_MAX);
  localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, SETTLE = 2'd2} state_t;

  state_t                   state, state_n;
  logic [1:0]               rr_ptr, sel_q, grant_idx;
  logic                     grant_vld;
  logic [GAIN_W-1:0]        inc_q, inc_sel, cur_gain, new_gain;
  logic signed [SUM_W-1:0]  sum;
  logic                     clamped;
  logic [CNT_W-1:0]         cnt;

  // Circular offset from the round-robin pointer (base <= 2, k <= 2).
  function automatic logic [1:0] wrap3(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  // Pick the first requesting gain at or after rr_ptr; scanning backwards lets the nearest win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (req[wrap3(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap3(rr_ptr, k);
      end
    end
  end

  // Increment of the gain being granted, and current value of the gain being applied.
  always_comb begin
    inc_sel  = inc_kd;
    cur_gain = kd;
    case (grant_idx)
      2'd0:    inc_sel = inc_kp;
      2'd1:    inc_sel = inc_ki;
      default: inc_sel = inc_kd;
    endcase
    case (sel_q)
      2'd0:    cur_gain = kp;
      2'd1:    cur_gain = ki;
      default: cur_gain = kd;
    endcase
  end

  // Widened signed add keeps a negative or overflowing result visible for the clamp.
  always_comb begin
    sum      = $signed({2'b00, cur_gain}) + $signed({{2{inc_q[GAIN_W-1]}}, inc_q});
    clamped  = 1'b0;
    new_gain = sum[GAIN_W-1:0];
    if (sum < MIN_S) begin
      clamped  = 1'b1;
      new_gain = GAIN_W'(G_MIN);
    end else if (sum > MAX_S) begin
      clamped  = 1'b1;
      new_gain = GAIN_W'(G_MAX);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!freeze && grant_vld) state_n = APPLY;
      APPLY:   state_n = SETTLE;
      SETTLE:  if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Grant latch, gain update, ack pulse and settle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp       <= GAIN_W'(KP_INIT);
      ki       <= GAIN_W'(KI_INIT);
      kd       <= GAIN_W'(KD_INIT);
      ack      <= '0;
      sat_flag <= '0;
      rr_ptr   <= '0;
      sel_q    <= '0;
      inc_q    <= '0;
      cnt      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (!freeze && grant_vld) begin
            sel_q <= grant_idx;
            inc_q <= inc_sel;
          end
        end
        APPLY: begin
          case (sel_q)
            2'd0: begin kp <= new_gain; sat_flag[0] <= clamped; ack <= 3'b001; end
            2'd1: begin ki <= new_gain; sat_flag[1] <= clamped; ack <= 3'b010; end
            default: begin kd <= new_gain; sat_flag[2] <= clamped; ack <= 3'b100; end
          endcase
          rr_ptr <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          cnt    <= CNT_LOAD;
        end
        SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_update_sched.sv
// Self-checking bench for gain_update_sched: directed table, hand-written
// corner sequences, and a randomized run against a timeline/arith model.
module tb_gain_update_sched;

  localparam int GAIN_W     = 8;
  localparam int SETTLE_CYC = 16;
  localparam int KP_INIT    = 12;
  localparam int KI_INIT    = 4;
  localparam int KD_INIT    = 0;
  localparam int G_MIN      = 3;
  localparam int G_MAX      = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        req = '0;
  logic [GAIN_W-1:0] inc_kp = '0, inc_ki = '0, inc_kd = '0;
  logic              freeze = 1'b0;
  logic [GAIN_W-1:0] kp, ki, kd;
  logic [2:0]        ack, sat_flag;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  gain_update_sched #(
    .GAIN_W(GAIN_W), .SETTLE_CYC(SETTLE_CYC), .KP_INIT(KP_INIT), .KI_INIT(KI_INIT),
    .KD_INIT(KD_INIT), .G_MIN(G_MIN), .G_MAX(G_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .inc_kp(inc_kp), .inc_ki(inc_ki), .inc_kd(inc_kd),
    .freeze(freeze), .kp(kp), .ki(ki), .kd(kd), .ack(ack), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sel;
    int inc;
    int exp_gain;
    int exp_sat;
  } row_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gain_of(input int g);
    if (g == 0) return int'(kp);
    if (g == 1) return int'(ki);
    return int'(kd);
  endfunction

  // Saturating add from the block's rules, in plain integer arithmetic.
  task automatic model_add(input int g, input logic [7:0] inc, output int ng, output int sat);
    int s;
    s = g + int'($signed(inc));
    sat = 0;
    ng = s;
    if (s < G_MIN) begin ng = G_MIN; sat = 1; end
    else if (s > G_MAX) begin ng = G_MAX; sat = 1; end
  endtask

  task automatic set_inc(input int g, input logic [7:0] v);
    if (g == 0) inc_kp = v;
    else if (g == 1) inc_ki = v;
    else inc_kd = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a nonzero ack, sampling on negedges.
  task automatic wait_ack(input int max_cyc, output int edge_no, output int ok);
    ok = 0; edge_no = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin ok = 1; edge_no = cyc; break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // One isolated update of a single gain; checks latency, ack pulse, gain and sat.
  task automatic apply_row(input row_t r, input string tag);
    int e, ae, ok;
    wait_idle();
    e = cyc;
    set_inc(r.sel, 8'(r.inc));
    req = 3'(1 << r.sel);
    wait_ack(40, ae, ok);
    chk({tag, "_ack_seen"}, ok, 1);
    chk({tag, "_latency"}, ae - e, 2);
    chk({tag, "_ack"}, int'(ack), 1 << r.sel);
    req = '0;
    chk({tag, "_gain"}, gain_of(r.sel), r.exp_gain);
    chk({tag, "_sat"}, int'(sat_flag[r.sel]), r.exp_sat);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, int'(ack), 0);
  endtask

  row_t rows[12];

  initial begin
    int e, ae, ok, cnt, any_ack;
    int exp_order[4];
    int mg[3], ms[3], ptr, free_edge, pend, g, grant_edge, f, rel, ng, sat, add_m;
    logic [7:0] minc[3];

    rows[0]  = '{0, -20,   3, 1};
    rows[1]  = '{0,   1,   4, 0};
    rows[2]  = '{0, 116, 120, 0};
    rows[3]  = '{0, 127, 128, 1};
    rows[4]  = '{0,   0, 128, 0};
    rows[5]  = '{2,   0,   3, 1};
    rows[6]  = '{1, -128,  3, 1};
    rows[7]  = '{1, 127, 128, 1};
    rows[8]  = '{2,  -1,   3, 1};
    rows[9]  = '{2, 125, 128, 0};
    rows[10] = '{1, -125,  3, 0};
    rows[11] = '{1,  -1,   3, 1};

    // Reset values.
    do_reset();
    @(negedge clk);
    chk("rst_kp", int'(kp), KP_INIT);
    chk("rst_ki", int'(ki), KI_INIT);
    chk("rst_kd", int'(kd), KD_INIT);
    chk("rst_ack", int'(ack), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_busy", int'(busy), 0);

    // First update: +5 on kp, busy spans APPLY plus the settle interval.
    e = cyc;
    inc_kp = 8'd5; req = 3'b001;
    cnt = 0; ae = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (ack != 0 && ae < 0) begin ae = cyc; chk("t1_ack", int'(ack), 1); req = '0; end
    end
    chk("t1_latency", ae - e, 2);
    chk("t1_kp", int'(kp), 17);
    chk("t1_busy_len", cnt, 1 + SETTLE_CYC);

    // Table of single-gain updates.
    foreach (rows[i]) apply_row(rows[i], $sformatf("row%0d", i));

    // Held req=111: strict round robin, one ack per SETTLE_CYC+2 cycles.
    do_reset();
    @(negedge clk);
    e = cyc;
    inc_kp = 8'd1; inc_ki = 8'd1; inc_kd = 8'd1; req = 3'b111;
    exp_order = '{1, 2, 4, 1};
    for (int k = 0; k < 4; k++) begin
      wait_ack(40, ae, ok);
      chk($sformatf("rr_seen%0d", k), ok, 1);
      chk($sformatf("rr_order%0d", k), int'(ack), exp_order[k]);
      chk($sformatf("rr_time%0d", k), ae - e, 2 + k * (SETTLE_CYC + 2));
    end
    req = '0;
    chk("rr_kp", int'(kp), KP_INIT + 2);
    chk("rr_ki", int'(ki), KI_INIT + 1);
    chk("rr_kd", int'(kd), G_MIN);

    // Freeze blocks the grant; release lets it through two cycles later.
    wait_idle();
    do_reset();
    @(negedge clk);
    freeze = 1'b1; inc_ki = 8'd10; req = 3'b010;
    any_ack = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != 0) any_ack = 1;
    end
    chk("frz_no_ack", any_ack, 0);
    chk("frz_ki", int'(ki), KI_INIT);
    chk("frz_busy", int'(busy), 0);
    freeze = 1'b0;
    e = cyc;
    wait_ack(40, ae, ok);
    chk("frz_rel_latency", ae - e, 2);
    chk("frz_rel_ack", int'(ack), 2);
    chk("frz_rel_ki", int'(ki), KI_INIT + 10);
    req = '0;

    // Reset during SETTLE after a clamping kp update.
    wait_idle();
    inc_kp = 8'(-20); req = 3'b001;
    wait_ack(40, ae, ok);
    req = '0;
    chk("rs_pre_sat", int'(sat_flag), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_kp", int'(kp), KP_INIT);
    chk("rs_ki", int'(ki), KI_INIT);
    chk("rs_kd", int'(kd), KD_INIT);
    chk("rs_ack", int'(ack), 0);
    chk("rs_sat", int'(sat_flag), 0);
    chk("rs_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in APPLY discards the latched increment.
    @(negedge clk);
    inc_ki = 8'd50; req = 3'b010;
    @(negedge clk);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    any_ack = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack != 0) any_ack = 1;
    end
    chk("ra_no_ack", any_ack, 0);
    chk("ra_ki", int'(ki), KI_INIT);

    // Randomized traffic against a timeline model.
    do_reset();
    @(negedge clk);
    mg = '{KP_INIT, KI_INIT, KD_INIT};
    ms = '{0, 0, 0};
    ptr = 0; free_edge = 0; pend = 0;
    minc = '{8'd0, 8'd0, 8'd0};
    for (int t = 0; t < 60; t++) begin
      add_m = int'($urandom_range(0, 7));
      if ((pend | add_m) == 0) add_m = 1 << $urandom_range(0, 2);
      for (int b = 0; b < 3; b++) begin
        if (add_m[b] && !pend[b]) begin
          minc[b] = 8'($urandom_range(0, 255));
          set_inc(b, minc[b]);
        end
      end
      pend = pend | add_m;
      req = 3'(pend);
      e = cyc;
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0;
      grant_edge = (free_edge > e + 1) ? free_edge : e + 1;
      if (f > 0) begin
        freeze = 1'b1;
        repeat (f) @(negedge clk);
        freeze = 1'b0;
        rel = cyc;
        if (rel + 1 > grant_edge) grant_edge = rel + 1;
      end
      g = -1;
      for (int k = 2; k >= 0; k--) if (pend[(ptr + k) % 3]) g = (ptr + k) % 3;
      wait_ack(120, ae, ok);
      chk("rnd_ack_seen", ok, 1);
      if (ok == 0) break;
      chk("rnd_ack", int'(ack), 1 << g);
      chk("rnd_time", ae, grant_edge + 1);
      model_add(mg[g], minc[g], ng, sat);
      mg[g] = ng; ms[g] = sat;
      chk("rnd_kp", int'(kp), mg[0]);
      chk("rnd_ki", int'(ki), mg[1]);
      chk("rnd_kd", int'(kd), mg[2]);
      chk("rnd_sat", int'(sat_flag), ms[0] + 2 * ms[1] + 4 * ms[2]);
      free_edge = ae + SETTLE_CYC + 1;
      ptr = (g + 1) % 3;
      pend[g] = 1'b0;
      req = 3'(pend);
    end
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
